// File: rtl/vram_slot_arbiter.sv
// Time-slot arbiter sharing the 16-bit bitmap VRAM between video fetch and CPU byte accesses.
// Define VRAM_CPU_ACTIVE_EN to also grant the CPU phases 1-3 of active display.
module vram_slot_arbiter #(
   parameter int AW     = 14,
   parameter int CPU_AW = 15
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ce5,
   input  logic [8:0]        hcount,
   input  logic [7:0]        vcount,
   input  logic              hblank,
   input  logic              vblank,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [CPU_AW-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic              cpu_ack,
   output logic [7:0]        cpu_rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [1:0]        ram_be,
   output logic [AW-1:0]     ram_addr,
   output logic [15:0]       ram_wdata,
   input  logic [15:0]       ram_rdata,
   output logic [15:0]       vid_data,
   output logic              vid_strobe
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ISSUE   = 2'd1;
   localparam logic [1:0] CAPTURE = 2'd2;

   logic [1:0] state;
   logic       owner_cpu;
   logic       lane_hi;
   logic       video_slot;
   logic       cpu_slot;
   logic       unused_hcount_msb;

   // Blanking alone decides whether pixel 256+ is fetched, so the count MSB is not needed.
   assign unused_hcount_msb = hcount[8];

   always_comb begin
      video_slot = (hcount[1:0] == 2'b00) && !hblank && !vblank;
`ifdef VRAM_CPU_ACTIVE_EN
      cpu_slot   = !video_slot;
`else
      cpu_slot   = hblank || vblank;
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         owner_cpu  <= 1'b0;
         lane_hi    <= 1'b0;
         ram_en     <= 1'b0;
         ram_we     <= 1'b0;
         ram_be     <= 2'b00;
         ram_addr   <= '0;
         ram_wdata  <= 16'h0000;
         cpu_ack    <= 1'b0;
         cpu_rdata  <= 8'h00;
         vid_data   <= 16'h0000;
         vid_strobe <= 1'b0;
      end else begin
         ram_en     <= 1'b0;
         cpu_ack    <= 1'b0;
         vid_strobe <= 1'b0;
         case (state)
            IDLE: begin
               // A slot only counts on a ce5 edge; the video fetch always beats a pending CPU request.
               if (ce5 && video_slot) begin
                  state     <= ISSUE;
                  ram_en    <= 1'b1;
                  ram_we    <= 1'b0;
                  ram_be    <= 2'b11;
                  ram_addr  <= AW'({vcount, hcount[7:2]});
                  owner_cpu <= 1'b0;
               end else if (ce5 && cpu_slot && cpu_req) begin
                  state     <= ISSUE;
                  ram_en    <= 1'b1;
                  ram_we    <= cpu_we;
                  ram_be    <= cpu_addr[0] ? 2'b10 : 2'b01;
                  ram_addr  <= cpu_addr[CPU_AW-1:1];
                  ram_wdata <= {cpu_wdata, cpu_wdata};
                  lane_hi   <= cpu_addr[0];
                  owner_cpu <= 1'b1;
               end
            end
            ISSUE: begin
               state <= CAPTURE;
            end
            CAPTURE: begin
               state <= IDLE;
               if (owner_cpu) begin
                  cpu_ack <= 1'b1;
                  if (!ram_we) begin
                     cpu_rdata <= lane_hi ? ram_rdata[15:8] : ram_rdata[7:0];
                  end
               end else begin
                  vid_data   <= ram_rdata;
                  vid_strobe <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Scoreboard bench for vram_slot_arbiter: stimulus queues expected RAM commands, acks and video words.
// Expectations follow VRAM_CPU_ACTIVE_EN when the bench is built with it.
module tb_vram_slot_arbiter;

   typedef struct {
      int          cyc;
      logic        we;
      logic [1:0]  be;
      logic [13:0] addr;
      logic [15:0] wdata;
      logic        chkW;
   } cmd_t;

   typedef struct {
      int         cyc;
      logic [7:0] rdata;
   } ack_t;

   typedef struct {
      int          cyc;
      logic [15:0] data;
   } vid_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        ce5 = 1'b0;
   logic [8:0]  hcount = '0;
   logic [7:0]  vcount = '0;
   logic        hblank = 1'b0;
   logic        vblank = 1'b0;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [14:0] cpu_addr = '0;
   logic [7:0]  cpu_wdata = '0;
   logic        cpu_ack;
   logic [7:0]  cpu_rdata;
   logic        ram_en;
   logic        ram_we;
   logic [1:0]  ram_be;
   logic [13:0] ram_addr;
   logic [15:0] ram_wdata;
   logic [15:0] ram_rdata = '0;
   logic [15:0] vid_data;
   logic        vid_strobe;

   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   logic        probe = 1'b0;
   int          probeMode = 0;
   logic        holdReq = 1'b0;
   logic [7:0]  lastRdata = 8'h00;
   logic [15:0] refMem [0:16383];
   logic [15:0] ram [0:16383];
   logic        ramInit = 1'b0;

   cmd_t cmdQ[$];
   ack_t ackQ[$];
   vid_t vidQ[$];
   cmd_t cmdExp;
   ack_t ackExp;
   vid_t vidExp;

   vram_slot_arbiter #(.AW(14), .CPU_AW(15)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ce5        (ce5),
      .hcount     (hcount),
      .vcount     (vcount),
      .hblank     (hblank),
      .vblank     (vblank),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_ack    (cpu_ack),
      .cpu_rdata  (cpu_rdata),
      .ram_en     (ram_en),
      .ram_we     (ram_we),
      .ram_be     (ram_be),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata),
      .vid_data   (vid_data),
      .vid_strobe (vid_strobe)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   function automatic logic [15:0] initWord(int i);
      if (i == 'h0A02) return 16'h1234;
      if (i == 'h091A) return 16'hABCD;
      return 16'(i) ^ 16'hC35A;
   endfunction

   // Synchronous RAM with byte enables; read data appears the cycle after ram_en is sampled.
   always @(posedge clk) begin
      if (!ramInit) begin
         for (int i = 0; i < 16384; i++) ram[i] <= initWord(i);
         ramInit <= 1'b1;
      end
      if (ram_en) begin
         if (ram_we) begin
            if (ram_be[0]) ram[ram_addr][7:0]  <= ram_wdata[7:0];
            if (ram_be[1]) ram[ram_addr][15:8] <= ram_wdata[15:8];
         end else begin
            ram_rdata <= ram[ram_addr];
         end
      end
   end

   task automatic checkOutput(input string name, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Monitor: pops an expectation whenever the DUT presents a command, ack or video strobe.
   always @(negedge clk or posedge probe) begin
      if (probe) begin
         if (probeMode == 0) begin
            checkOutput("reset ram_en",     48'(ram_en),     48'(0));
            checkOutput("reset ram_we",     48'(ram_we),     48'(0));
            checkOutput("reset ram_be",     48'(ram_be),     48'(0));
            checkOutput("reset ram_addr",   48'(ram_addr),   48'(0));
            checkOutput("reset ram_wdata",  48'(ram_wdata),  48'(0));
            checkOutput("reset cpu_ack",    48'(cpu_ack),    48'(0));
            checkOutput("reset cpu_rdata",  48'(cpu_rdata),  48'(0));
            checkOutput("reset vid_data",   48'(vid_data),   48'(0));
            checkOutput("reset vid_strobe", 48'(vid_strobe), 48'(0));
         end else begin
            checkOutput("pending commands", 48'(cmdQ.size()), 48'(0));
            checkOutput("pending acks",     48'(ackQ.size()), 48'(0));
            checkOutput("pending video",    48'(vidQ.size()), 48'(0));
         end
      end else if (reset_n) begin
         if (ram_en) begin
            if (cmdQ.size() == 0) begin
               checkOutput("unexpected ram_en", 48'(ram_en), 48'(0));
            end else begin
               cmdExp = cmdQ.pop_front();
               checkOutput("command cycle", 48'(cyc), 48'(cmdExp.cyc));
               checkOutput("command we/be/addr", 48'({ram_we, ram_be, ram_addr}),
                           48'({cmdExp.we, cmdExp.be, cmdExp.addr}));
               if (cmdExp.chkW) checkOutput("command wdata", 48'(ram_wdata), 48'(cmdExp.wdata));
            end
         end
         if (cpu_ack) begin
            if (ackQ.size() == 0) begin
               checkOutput("unexpected cpu_ack", 48'(cpu_ack), 48'(0));
            end else begin
               ackExp = ackQ.pop_front();
               checkOutput("ack cycle", 48'(cyc), 48'(ackExp.cyc));
               checkOutput("ack rdata", 48'(cpu_rdata), 48'(ackExp.rdata));
            end
         end
         if (vid_strobe) begin
            if (vidQ.size() == 0) begin
               checkOutput("unexpected vid_strobe", 48'(vid_strobe), 48'(0));
            end else begin
               vidExp = vidQ.pop_front();
               checkOutput("video cycle", 48'(cyc), 48'(vidExp.cyc));
               checkOutput("video data", 48'(vid_data), 48'(vidExp.data));
            end
         end
      end
   end

   // One pixel slot (ce5 then three idle clocks), entered and left on a falling edge.
   task automatic applyStimulus(input int h, input int v);
      logic [13:0] a;
      logic        blank;
      logic        vslot;
      logic        cslot;
      hcount = 9'(h);
      vcount = 8'(v);
      hblank = (h >= 256);
      vblank = (v < 24);
      ce5    = 1'b1;
      blank  = hblank || vblank;
      vslot  = (h % 4 == 0) && !blank;
`ifdef VRAM_CPU_ACTIVE_EN
      cslot  = !vslot;
`else
      cslot  = blank;
`endif
      if (vslot) begin
         a = 14'((v % 256) * 64 + (h % 256) / 4);
         cmdQ.push_back('{cyc + 1, 1'b0, 2'b11, a, 16'h0000, 1'b0});
         vidQ.push_back('{cyc + 3, refMem[a]});
      end else if (cslot && cpu_req) begin
         a = cpu_addr[14:1];
         cmdQ.push_back('{cyc + 1, cpu_we, cpu_addr[0] ? 2'b10 : 2'b01, a, {cpu_wdata, cpu_wdata}, cpu_we});
         if (cpu_we) begin
            if (cpu_addr[0]) refMem[a][15:8] = cpu_wdata;
            else             refMem[a][7:0]  = cpu_wdata;
         end else begin
            lastRdata = cpu_addr[0] ? refMem[a][15:8] : refMem[a][7:0];
         end
         ackQ.push_back('{cyc + 3, lastRdata});
      end
      @(negedge clk);
      ce5 = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (cpu_ack && !holdReq) cpu_req = 1'b0;
      end
   endtask

   initial begin
      int h;
      for (int i = 0; i < 16384; i++) refMem[i] = initWord(i);
      #1 reset_n = 1'b0;
      #2 probeMode = 0;
      probe = 1'b1;
      #1 probe = 1'b0;
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b1;
      @(negedge clk);

      // Active line 40 with no CPU traffic: one fetch at hcount 8.
      for (int x = 8; x < 12; x++) applyStimulus(x, 40);

      // CPU read raised on a video phase of line 40.
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 15'h1235;
      h = 12;
      while (h < 320 && cpu_req) begin
         applyStimulus(h, 40);
         h++;
      end
      cpu_req = 1'b0;

      // Write during vblank, then read both lanes of the same word back.
      cpu_req   = 1'b1;
      cpu_we    = 1'b1;
      cpu_addr  = 15'h0010;
      cpu_wdata = 8'h5A;
      applyStimulus(0, 5);
      cpu_we   = 1'b0;
      cpu_req  = 1'b1;
      applyStimulus(1, 5);
      cpu_addr = 15'h0011;
      cpu_req  = 1'b1;
      applyStimulus(2, 5);
      cpu_req  = 1'b0;

      // Request withdrawn between two slots.
      cpu_addr = 15'h0020;
      cpu_req  = 1'b1;
      @(negedge clk);
      @(negedge clk);
      cpu_req = 1'b0;
      applyStimulus(3, 5);
      applyStimulus(4, 5);

      // Reset lands after the command of a CPU read is issued.
      hcount   = 9'd260;
      vcount   = 8'd10;
      hblank   = 1'b1;
      vblank   = 1'b1;
      cpu_addr = 15'h0100;
      cpu_req  = 1'b1;
      ce5      = 1'b1;
      cmdQ.push_back('{cyc + 1, 1'b0, 2'b01, 14'h0080, 16'h0000, 1'b0});
      @(negedge clk);
      ce5 = 1'b0;
      #1 reset_n = 1'b0;
      #1 probeMode = 0;
      probe = 1'b1;
      #1 probe = 1'b0;
      lastRdata = 8'h00;
      @(negedge clk);
      #2 reset_n = 1'b1;
      @(negedge clk);
      applyStimulus(261, 10);
      cpu_req = 1'b0;

      // Request held continuously across blanking and into active display.
      holdReq  = 1'b1;
      cpu_addr = 15'h0011;
      cpu_req  = 1'b1;
      for (int x = 262; x < 266; x++) applyStimulus(x, 10);
      for (int x = 0; x < 8; x++) applyStimulus(x, 60);
      holdReq = 1'b0;
      cpu_req = 1'b0;

      repeat (4) @(negedge clk);
      probeMode = 1;
      probe = 1'b1;
      #1 probe = 1'b0;
      #1 $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vram_slot_arbiter.md
# vram_slot_arbiter

Time-slot arbiter that shares the 16-bit-wide bitmap video RAM between the video fetch path and the CPU. It is driven by the pixel enable and the horizontal/vertical counters of the sync chain. It issues one video word fetch (4 pixels × 4 bpp) every fourth pixel during active display. All other pixel slots are granted to the CPU through a req/ack handshake.

## Interface
Parameters:
- `AW`, 14: RAM word-address width.
- `CPU_AW`, 15: CPU byte-address width; must equal `AW`+1.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `ce5`  in  1  pixel clock enable; asserted at most once every 3 `clk`.
- `hcount`  in  9  horizontal pixel count, 0..319.
- `vcount`  in  8  line count.
- `hblank`  in  1  high on blanked pixels (`hcount`≥256).
- `vblank`  in  1  high on blanked lines (0..23).
- `cpu_req`  in  1  CPU access request; held until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read; stable while `cpu_req`.
- `cpu_addr`  in  `CPU_AW`  byte address; bit 0 selects the lane (0 = low byte).
- `cpu_wdata`  in  8  write byte.
- `cpu_ack`  out  1  one-`clk` completion pulse.
- `cpu_rdata`  out  8  read byte; valid with `cpu_ack`, held until the next ack.
- `ram_en`  out  1  RAM command strobe, one `clk` wide.
- `ram_we`  out  1  RAM write enable.
- `ram_be`  out  2  byte enables.
- `ram_addr`  out  `AW`  RAM word address.
- `ram_wdata`  out  16  write data; the CPU byte is replicated to both lanes.
- `ram_rdata`  in  16  synchronous read data; valid the cycle after the edge that sampled `ram_en`.
- `vid_data`  out  16  fetched pixel word.
- `vid_strobe`  out  1  one-`clk` pulse when `vid_data` updates.

## Operation
- Slot phase is `hcount[1:0]`, evaluated on `clk` edges with `ce5`=1.
- **Video slot:** phase 0 with `hblank`=0 and `vblank`=0.
  - Issues a read at `ram_addr`={`vcount`, `hcount[7:2]`}.
  - The video slot always wins. A CPU request pending at the same time waits for the next CPU slot.
- **CPU slot:** phases 1–3 during active display, or any phase while `hblank` or `vblank` is high.
  - If `cpu_req`=1 and the FSM is in IDLE, the CPU access is accepted.
  - `ram_addr`=`cpu_addr[CPU_AW-1:1]`.
  - `ram_be`=2'b01 when `cpu_addr[0]`=0, 2'b10 when it is 1; `ram_be`=2'b11 for video reads.
- **FSM states:** IDLE → ISSUE → CAPTURE → IDLE.
  - ISSUE: `ram_en`=1 for exactly one `clk`.
  - CAPTURE: for a CPU access, latch the selected byte of `ram_rdata` into `cpu_rdata` (reads only) and pulse `cpu_ack` (reads and writes). For a video access, latch `ram_rdata` into `vid_data` and pulse `vid_strobe`.
  - An owner flag records whether the access belongs to the video path or the CPU.
- At most one access is in flight. A `ce5` slot arriving in a non-IDLE state is forfeited. This cannot occur when the `ce5` spacing is ≥3 `clk`.
- **Request withdrawal:**
  - `cpu_req` dropped before acceptance: no access, no ack.
  - After acceptance: the access completes and `cpu_ack` still pulses.
- **Back-to-back requests:** `cpu_req` still high on the ack cycle is a new request, eligible from the next `ce5` slot.
- **Wrap-around:** `hcount` 319→0 and `vcount` 255→0 need no special handling. Blanking inputs alone gate the video slots.

## Timing
- **Reset values:** `ram_en`=0, `ram_we`=0, `ram_be`=0, `ram_addr`=0, `ram_wdata`=0, `cpu_ack`=0, `cpu_rdata`=0, `vid_data`=0, `vid_strobe`=0, FSM=IDLE.
- **Reset mid-operation:** the access is aborted and no ack or strobe is emitted.
- **Latency:**
  - Edge E0 (`ce5`=1, slot won): command registered; `ram_en` high during E0–E1.
  - Edge E1: RAM samples the command.
  - Edge E2: data captured; `cpu_ack`/`vid_strobe` high during E2–E3.
- **CPU worst-case wait during active display:**
  - With `VRAM_CPU_ACTIVE_EN`: 2 `ce5` periods plus 2 `clk`.
  - Without it: until the next blanking interval.

## Configuration
- Macro `VRAM_CPU_ACTIVE_EN`.
  - **Defined:** CPU slots exist on phases 1–3 during active display, as above.
  - **Undefined:** the CPU is granted only while `hblank` or `vblank` is high, matching the original board timing. Video slot behaviour is unchanged.

## Test plan
- Active line, `vcount`=40, `hcount`=8, no CPU request:
  - Required: `ram_addr`=0x0A02, `ram_be`=11, `ram_en` pulse at E0.
  - `ram_rdata`=0x1234 → `vid_data`=0x1234 and `vid_strobe` at E2.
- CPU read raised at phase 0 of an active slot (`VRAM_CPU_ACTIVE_EN` defined), `cpu_addr`=0x1235, RAM word 0xABCD:
  - Video read issues first.
  - CPU read issues at phase 1 with `ram_addr`=0x091A, `ram_be`=10.
  - `cpu_ack` with `cpu_rdata`=0xAB.
- CPU write during `vblank`, `cpu_addr`=0x0010, `cpu_wdata`=0x5A:
  - Issues at the first `ce5` with `ram_we`=1, `ram_be`=01, `ram_wdata`=0x5A5A.
  - `cpu_ack` at E2.
- Same active-display request with `VRAM_CPU_ACTIVE_EN` undefined:
  - No grant until `hblank` rises at `hcount`=256, then ack within 1 `ce5` + 2 `clk`.
- Assert `reset_n`=0 between E0 and E2 of a CPU read:
  - All outputs reach their reset values immediately.
  - No `cpu_ack` after release.
  - A held `cpu_req` is re-served from IDLE.
- `cpu_req` dropped before acceptance, and `cpu_req` held continuously:
  - Dropped: no `ram_en` or ack.
  - Held: consecutive acks are each separated by ≥1 `ce5` slot and never collide with video slots.
